// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access-size
// encodings and the alignment check used when a request is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Size 11 is reserved and therefore never a legal access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = lo[0];
      SIZE_W:  misaligned = (lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Core-side request/response bus plus the data-memory strobes of the LSU.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// the requester holds all req_* stable until then. resp_valid is a one-cycle
// pulse with no backpressure; resp_rdata/resp_err are meaningful only with it.
interface lsu_mem_port_if #(parameter int ADDR_W = 16) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_read;
  logic              mem_write;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );

endinterface

// File: rtl/lsu_lane_merge.sv
// Little-endian lane logic: merges store data into an old word and extracts
// (zero/sign-extended) load data from a read word. Purely combinational.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_word,
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        is_signed,
  output logic [31:0] new_word,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    new_word = old_word;
    case (size)
      SIZE_B:  new_word[{lo, 3'b000} +: 8]     = wdata[7:0];
      SIZE_H:  new_word[{lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: new_word = wdata;
    endcase
  end

  always_comb begin
    byte_v = rd_word[{lo, 3'b000} +: 8];
    half_v = rd_word[{lo[1], 4'b0000} +: 16];
    case (size)
      SIZE_B:  load_data = {{24{is_signed & byte_v[7]}}, byte_v};
      SIZE_H:  load_data = {{16{is_signed & half_v[15]}}, half_v};
      default: load_data = rd_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator for a word-wide data memory; sub-word stores use
// read-modify-write. Byte/halfword support is compiled in with LSU_SUBWORD_EN.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16
)
(
  input  logic          clock,
  input  logic          rst,
  lsu_mem_port_if.slave bus,
  output lsu_state_e    dbg_state
);

  lsu_state_e        state, state_nx;
  logic [ADDR_W-3:0] waddr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              write_q;
  logic              err_q;
  logic              req_err;
  logic              accept;
  logic [31:0]       store_word;
  logic [31:0]       load_word;

  assign accept    = (state == IDLE) && bus.req_valid;
  assign dbg_state = state;

`ifdef LSU_SUBWORD_EN
  assign req_err = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign req_err = misaligned(bus.req_size, bus.req_addr[1:0]) || (bus.req_size != SIZE_W);
`endif

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err)                                    state_nx = RESP;
          else if (bus.req_write && bus.req_size == SIZE_W) state_nx = WRITE;
          else                                            state_nx = READ;
        end
      end
`ifdef LSU_SUBWORD_EN
      READ:    state_nx = write_q ? WRITE : RESP;
`else
      READ:    state_nx = RESP;
`endif
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // rdata_q is cleared on accept so stores and errors respond with zero.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        waddr_q <= bus.req_addr[ADDR_W-1:2];
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
        write_q <= bus.req_write;
        err_q   <= req_err;
      end
      if (state == READ && !write_q) rdata_q <= load_word;
    end
  end

`ifdef LSU_SUBWORD_EN
  logic [1:0]  lo_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] word_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      lo_q     <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      word_q   <= '0;
    end else begin
      if (accept) begin
        lo_q     <= bus.req_addr[1:0];
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
      end
      if (state == READ) word_q <= bus.mem_rdata;
    end
  end

  lsu_lane_merge u_lane_merge (
    .old_word  (word_q),
    .wdata     (wdata_q),
    .rd_word   (bus.mem_rdata),
    .size      (size_q),
    .lo        (lo_q),
    .is_signed (signed_q),
    .new_word  (store_word),
    .load_data (load_word)
  );
`else
  assign store_word = wdata_q;
  assign load_word  = bus.mem_rdata;
`endif

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    case (state)
      IDLE: bus.req_ready = 1'b1;
      READ: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = {waddr_q, 2'b00};
      end
      WRITE: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = {waddr_q, 2'b00};
        bus.mem_wdata = store_word;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        bus.resp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: byte-array reference model, word memory driven by the
// DUT strobes, response scoreboard with latency tracking, and a mid-write reset.
module tb_lsu_mem_port;
  import lsu_pkg::*;

`ifdef LSU_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic       clock;
  logic       rst;
  logic       mem_clear;
  lsu_state_e dbg_state;

  lsu_mem_port_if #(.ADDR_W(16)) bus ();

  lsu_mem_port #(.ADDR_W(16)) dut (
    .clock     (clock),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Word memory: combinational read while mem_read, write on rising edge.
  logic [31:0] mem_arr [0:15];
  always_comb bus.mem_rdata = bus.mem_read ? mem_arr[bus.mem_addr[5:2]] : 32'hDEAD_BEEF;
  always @(posedge clock) begin
    if (mem_clear) for (int i = 0; i < 16; i++) mem_arr[i] <= '0;
    else if (bus.mem_write) mem_arr[bus.mem_addr[5:2]] <= bus.mem_wdata;
  end

  logic [7:0]  mb [0:63];
  logic [32:0] exp_q [$];
  int          lat_q [$];
  int          acc_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [15:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [32:0] mon_e;
  int          mon_acc;
  int          mon_lat;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic ref_err(input logic [1:0] sz, input logic [15:0] a);
    case (sz)
      2'd0:    return !SUBWORD;
      2'd1:    return !SUBWORD || a[0];
      2'd2:    return a[1:0] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [15:0] a);
    int b;
    b = int'(a[5:2]) * 4;
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [15:0] a, input logic [1:0] sz, input logic sg);
    int b;
    logic [31:0] v;
    b = int'(a[5:0]);
    case (sz)
      2'd0: begin
        v = {24'h0, mb[b]};
        if (sg && mb[b][7]) v[31:8] = '1;
      end
      2'd1: begin
        v = {16'h0, mb[b+1], mb[b]};
        if (sg && mb[b+1][7]) v[31:16] = '1;
      end
      default: v = {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [15:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int b;
    b = int'(a[5:0]);
    mb[b] = wd[7:0];
    if (sz != 2'd0) mb[b+1] = wd[15:8];
    if (sz == 2'd2) begin
      mb[b+2] = wd[23:16];
      mb[b+3] = wd[31:24];
    end
  endtask

  // Response monitor: pops the scoreboard on every resp_valid pulse.
  always @(negedge clock) begin
    cyc++;
    if (bus.mem_write) begin
      wr_cnt++;
      last_wr_addr = bus.mem_addr;
      last_wr_data = bus.mem_wdata;
    end
    if (bus.mem_read) rd_cnt++;
    if (bus.resp_valid) begin
      check("mem_quiet_in_resp", {bus.mem_read, bus.mem_write}, 2'b00);
      if (exp_q.size() == 0) begin
        check("resp_unexpected", bus.resp_valid, 1'b0);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_acc = acc_q.pop_front();
        mon_lat = lat_q.pop_front();
        check("resp_rdata", bus.resp_rdata, mon_e[31:0]);
        check("resp_err", bus.resp_err, mon_e[32]);
        check("resp_latency", cyc - mon_acc, mon_lat);
      end
    end
  end

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [15:0] addr, input logic [31:0] wd);
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          n_wr;
    int          n_rd;
    int          wc;
    int          rc;
    err  = ref_err(sz, addr);
    rd   = (err || wr) ? 32'h0 : ref_load(addr, sz, sg);
    lat  = err ? 1 : ((wr && sz != SIZE_W) ? 3 : 2);
    n_wr = (!err && wr) ? 1 : 0;
    n_rd = (!err && (!wr || sz != SIZE_W)) ? 1 : 0;
    @(negedge clock);
    check("req_ready_idle", bus.req_ready, 1'b1);
    wc = wr_cnt;
    rc = rd_cnt;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    @(posedge clock);
    exp_q.push_back({err, rd});
    lat_q.push_back(lat);
    acc_q.push_back(cyc);
    #1 bus.req_valid = 1'b0;
    @(negedge clock);
    check("req_ready_busy", bus.req_ready, 1'b0);
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      check("resp_timeout", exp_q.size(), 0);
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
    end
    check("mem_write_cycles", wr_cnt - wc, n_wr);
    check("mem_read_cycles", rd_cnt - rc, n_rd);
    if (!err && wr) begin
      ref_store(addr, sz, wd);
      check("mem_wr_addr", last_wr_addr, {addr[15:2], 2'b00});
      check("mem_wr_data", last_wr_data, ref_word(addr));
    end
  endtask

  initial begin
    logic [1:0]  rt_size;
    logic [15:0] rt_addr;
    logic [31:0] rt_data;
    rst            = 1'b0;
    mem_clear      = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    for (int i = 0; i < 64; i++) mb[i] = 8'h00;
    repeat (3) @(negedge clock);

    check("rst_state", dbg_state, IDLE);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_resp_err", bus.resp_err, 1'b0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 16'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    mem_clear = 1'b0;
    rst       = 1'b1;

    do_req(1'b1, SIZE_W, 1'b0, 16'h0004, 32'h1122_3344);
    do_req(1'b0, SIZE_W, 1'b0, 16'h0004, 32'h0);
    do_req(1'b1, SIZE_B, 1'b0, 16'h0005, 32'h0000_00AB);
    do_req(1'b0, SIZE_W, 1'b0, 16'h0004, 32'h0);
    do_req(1'b1, SIZE_W, 1'b0, 16'h0008, 32'h0000_8080);
    do_req(1'b0, SIZE_B, 1'b1, 16'h0008, 32'h0);
    do_req(1'b0, SIZE_B, 1'b0, 16'h0008, 32'h0);
    do_req(1'b0, SIZE_H, 1'b0, 16'h0008, 32'h0);
    do_req(1'b0, SIZE_H, 1'b1, 16'h0008, 32'h0);
    do_req(1'b0, SIZE_H, 1'b1, 16'h0003, 32'h0);
    do_req(1'b0, SIZE_W, 1'b0, 16'h0002, 32'h0);
    do_req(1'b1, 2'b11,  1'b0, 16'h0000, 32'hFFFF_FFFF);
    do_req(1'b1, SIZE_H, 1'b0, 16'h0006, 32'h1234_BEEF);
    do_req(1'b0, SIZE_W, 1'b0, 16'h0004, 32'h0);
    do_req(1'b0, SIZE_B, 1'b1, 16'h0007, 32'h0);
    do_req(1'b1, SIZE_W, 1'b0, 16'h0006, 32'h5555_AAAA);

    for (int n = 0; n < 40; n++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             16'($urandom_range(0, 63)), $urandom);
    end

    // Reset while the store is in its WRITE cycle: no write, no response.
    rt_size = SUBWORD ? SIZE_B : SIZE_W;
    rt_addr = SUBWORD ? 16'h0009 : 16'h0008;
    rt_data = SUBWORD ? 32'h0000_005A : 32'hCAFE_F00D;
    @(negedge clock);
    bus.req_write  = 1'b1;
    bus.req_size   = rt_size;
    bus.req_signed = 1'b0;
    bus.req_addr   = rt_addr;
    bus.req_wdata  = rt_data;
    bus.req_valid  = 1'b1;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.mem_write) break;
    end
    check("rst_reached_write", bus.mem_write, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_mem_write", bus.mem_write, 1'b0);
    check("rst_mid_mem_read", bus.mem_read, 1'b0);
    check("rst_mid_resp_valid", bus.resp_valid, 1'b0);
    check("rst_mid_req_ready", bus.req_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    rst = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_release_ready", bus.req_ready, 1'b1);
    check("rst_release_state", dbg_state, IDLE);
    check("rst_mem_unchanged", mem_arr[2], ref_word(16'h0008));
    do_req(1'b0, SIZE_W, 1'b0, 16'h0008, 32'h0);

    for (int i = 0; i < 16; i++) check("mem_final", mem_arr[i], ref_word(16'(i * 4)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator for the single-cycle MIPS datapath's word-wide data memory. It accepts byte, halfword and word load/store requests from the core, drives the memory's address, read and write strobes, and merges or extracts sub-word lanes. Sub-word stores use read-modify-write. It sits between the execute stage and the data memory, and replaces direct core control of memWrite and memRead.

## Interface
Parameters:
- ADDR_W, 16, byte-address width shared with the data memory.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous active-low reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  input  1  sign-extend load result (lb/lh); ignored for stores and words.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  load result, extended; 0 for stores and errors.
- resp_err  output  1  misaligned or unsupported access; valid with resp_valid.
- mem_addr  output  ADDR_W  word-aligned address ({req_addr[ADDR_W-1:2],2'b00}).
- mem_wdata  output  32  full merged word.
- mem_rdata  input  32  memory read data, combinational while mem_read high.
- mem_read  output  1  read strobe.
- mem_write  output  1  write strobe; memory writes on the rising edge.

## Operation
- Little-endian lanes: byte k = bits [8k+7:8k], selected by addr[1:0]; halfword h = addr[1].
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00; size 11 is always an error.
- Request latched on the rising edge when req_valid && req_ready. Requests while not ready are ignored; the requester holds them.
- FSM:
  - IDLE: go to RESP on error, WRITE on word store, otherwise READ.
  - READ: mem_read=1; mem_rdata captured into the word register; a load goes to RESP, a sub-word store goes to WRITE.
  - WRITE: mem_write=1, mem_wdata = captured word with the target lane replaced (word store: req_wdata unchanged); next state RESP.
  - RESP: resp_valid=1; next state IDLE.
- Load extraction: selected lane, zero- or sign-extended per req_signed.
- Error path: no mem_read or mem_write assertion; resp_rdata=0, resp_err=1.
- Outputs are registered or decoded from state. mem_* are 0 outside READ/WRITE.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Latency from the accept edge to the resp_valid cycle:
  - error: 1 cycle.
  - word store or any load: 2 cycles.
  - sub-word store: 3 cycles.
- req_ready returns the cycle after RESP. Maximum back-to-back throughput is one word load per 3 cycles.
- No response backpressure. resp_valid is a single-cycle pulse.
- Asynchronous reset mid-operation: mem_write and mem_read drop immediately, the pending op is discarded, and no response is produced. Reset asserted during WRITE before the edge causes no memory write.

## Configuration
- LSU_SUBWORD_EN defined: byte and halfword accesses supported as above.
- Undefined: only size 10 is legal. Sizes 00, 01 and 11 take the error path. The merge/extract logic and the READ→WRITE transition are removed, so stores are always single WRITE.

## Structure
- Package lsu_pkg:
  - state enum {IDLE, READ, WRITE, RESP}
  - size constants SIZE_B, SIZE_H, SIZE_W
  - misalignment check function
- Sub-module lsu_lane_merge (combinational):
  - store merge: old word, wdata, size, addr[1:0] → new word.
  - load extract: word, size, signed, addr[1:0] → result.

## Test plan
- Word store 0x11223344 @0x0004, then word load @0x0004 → mem_write for exactly one cycle with mem_addr=0x0004; load resp_rdata=0x11223344, resp_err=0, latency 2.
- sb 0xAB @0x0005 onto 0x11223344 → READ then WRITE with mem_wdata=0x1122AB44; resp_valid on the 3rd cycle after accept.
- Word 0x00008080 @0x0008:
  - lb signed @0x0008 → 0xFFFFFF80.
  - lbu @0x0008 → 0x00000080.
  - lhu @0x0008 → 0x00008080.
- lh @0x0003 and lw @0x0002 → resp_err=1, resp_rdata=0 one cycle after accept; mem_read and mem_write never asserted.
- Assert rst low during WRITE of a sub-word store → mem_write falls immediately, memory word unchanged, no resp_valid, req_ready=1 after release.
- Build without LSU_SUBWORD_EN: sb @0x0004 → resp_err=1, no memory access; word store still completes in 2 cycles.
